// File: rtl/sdram_word_responder.sv
// rtl/sdram_word_responder.sv - Avalon-MM word RAM responder with programmable stall and fixed read latency
module sdram_word_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic [3:0]  slave_byteenable,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [1:0]  err_flags
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  logic [31:0]             ram [DEPTH_WORDS];
  logic [3:0]              stall_cnt_q, stall_cnt_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [31:0]             dat_q [READ_LATENCY];
  logic [31:0]             dat_d [READ_LATENCY];
  logic [15:0]             rd_count_q, rd_count_d;
  logic [15:0]             wr_count_q, wr_count_d;
  logic [1:0]              err_q, err_d;

  logic          req;
  logic          accept;
  logic          wr_accept;
  logic          rd_accept;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_rdata;
  logic          unused_addr_hi;

  assign req               = slave_read | slave_write;
  assign slave_waitrequest = req && (stall_cnt_q != WAIT_LIM);
  assign accept            = req && !slave_waitrequest;
  assign wr_accept         = accept && slave_write;
  // A simultaneous read+write is treated as a write; the read half is dropped.
  assign rd_accept         = accept && slave_read && !slave_write;
  assign word_idx          = slave_address[2 +: AW];
  assign ram_rdata         = ram[word_idx];
  assign unused_addr_hi    = ^slave_address[31:AW+2];

  always_comb begin
    stall_cnt_d = '0;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    err_d       = err_q;
    vld_d       = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      dat_d[i] = dat_q[i];
    end

    if (req && !accept) begin
      stall_cnt_d = stall_cnt_q + 4'd1;
    end
    if (wr_accept) begin
      wr_count_d = wr_count_q + 16'd1;
    end
    if (rd_accept) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (accept && (slave_address[1:0] != 2'b00)) begin
      err_d[0] = 1'b1;
    end
    if (accept && slave_read && slave_write) begin
      err_d[1] = 1'b1;
    end

    // Data stages only load on a valid entry so the output word holds between pulses.
    vld_d[0] = rd_accept;
    if (rd_accept) begin
      dat_d[0] = ram_rdata;
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_q       <= '0;
      vld_q       <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      stall_cnt_q <= stall_cnt_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_q       <= err_d;
      vld_q       <= vld_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // RAM contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int k = 0; k < 4; k++) begin
        if (slave_byteenable[k]) begin
          ram[word_idx][8*k +: 8] <= slave_writedata[8*k +: 8];
        end
      end
    end
  end

  assign slave_readdatavalid = vld_q[READ_LATENCY-1];
  assign slave_readdata      = dat_q[READ_LATENCY-1];
  assign rd_count            = rd_count_q;
  assign wr_count            = wr_count_q;
  assign err_flags           = err_q;

endmodule
